data_memory_scheduler: RTL
==========================

// Module: data_memory_scheduler
// PURPOSE
//  Two-port burst scheduler in front of the single-port byte-wide data_memory (18-bit address).
//  Sequences one LANES-byte vector access per grant; requesters are p0 (vector LSU) and p1 (scalar/host).
//  Round-robin grant between p0 and p1.
//  Issues one byte address per cycle and packs/unpacks lane bytes; the sole driver of the data_memory ports.
// PARAMETERS
//  ADDR_W  18  byte address width, matches data_memory
//  DATA_W  8   memory word width
//  LANES   4   bytes per burst (>=1)
//  RD_LAT  1   cycles from mem_address issue until mem_q valid at a clk rising edge (>=1)
// PORTS
//  clk          in   1               single clock, rising edge
//  rst_n        in   1               asynchronous reset, active-low
//  pN_valid     in   1               (N=0,1) request pending; hold valid and fields until pN_ready
//  pN_we        in   1               1=write burst, 0=read burst
//  pN_addr      in   ADDR_W          base byte address
//  pN_wdata     in   LANES*DATA_W    write bytes; lane k in [8k+7:8k]
//  pN_ready     out  1               1-cycle accept strobe
//  pN_done      out  1               1-cycle completion strobe
//  pN_rdata     out  LANES*DATA_W    read bytes, same lane packing
//  mem_address  out  ADDR_W          to data_memory.address
//  mem_wren     out  1               to data_memory.wren
//  mem_data     out  DATA_W          to data_memory.data
//  mem_q        in   DATA_W          from data_memory.q
//  busy         out  1               high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (p0 first), lane=0, all outputs 0 including pN_rdata.
//   Taking effect asynchronously: mem_wren drops the instant rst_n falls.
//  States: IDLE -> BURST -> (write) DONE | (read) DRAIN -> DONE -> IDLE.
//  IDLE:
//   - Only one valid: grant that port. Both valid: grant the port selected by rr_ptr.
//   - Grant: pN_ready=1 that cycle; latch addr/we/wdata/port; lane=0; next state BURST.
//   - No valid: stay in IDLE; ready stays 0.
//  BURST, one cycle per lane:
//   - mem_address = base+lane, mod 2^ADDR_W (wraps 0x3FFFF->0x00000).
//   - mem_wren = latched we; mem_data = wdata lane slice.
//   - After lane LANES-1 is issued: write -> DONE, read -> DRAIN.
//  Read capture:
//   - mem_q sampled RD_LAT cycles after each issue, stored into the matching rdata lane.
//   - DRAIN lasts RD_LAT cycles, until the last lane is captured.
//  DONE (1 cycle):
//   - pN_done=1 for the granted port only.
//   - pN_rdata updated at DONE entry; stable until that port's next read DONE.
//   - Write DONE leaves pN_rdata unchanged.
//   - rr_ptr set to the other port; next state IDLE.
//  mem_wren=0 outside BURST and during read bursts.
//   mem_address holds the last issued value outside BURST; mem_data=0 outside write BURST.
//  Latency, accept cycle = 0:
//   - Write: lanes on cycles 1..LANES; done on cycle LANES+1.
//   - Read: done on cycle LANES+RD_LAT+1.
//   - Next accept no earlier than the cycle after DONE.
//  Non-granted port: ready stays 0 while busy; its request waits.
//   A requester dropping valid before its ready strobe is legal: no transaction.
//  Reset mid-operation: burst aborted, no done, unissued lanes never written; IDLE after release.
// TESTING
//  1 p0 write, addr 0x00000, wdata 0x44332211 (LANES=4)
//    -> mem writes 11@0, 22@1, 33@2, 44@3; p0_done on cycle 5.
//  2 p1 read, addr 0x00000, after test 1
//    -> p1_rdata=0x44332211; p1_done on cycle 6 (RD_LAT=1); mem_wren stays 0.
//  3 p0 and p1 valid together out of reset, both held -> order p0,p1,p0,p1;
//    only the granted port's done pulses; idle port's ready=0 while busy.
//  4 p0 write, addr 0x3FFFE -> mem_address 3FFFE,3FFFF,00000,00001 in order.
//  5 p1 read, addr 0x2AFFE, after writing AA..DD there -> p1_rdata=0xDDCCBBAA;
//    repeat with RD_LAT=3 -> done on cycle 8.
//  6 rst_n low during lane 2 of a write
//    -> mem_wren=0 immediately; no done; lanes 2,3 unchanged; busy=0; accept works after release.

Source files
------------

// File: rtl/data_memory_scheduler.sv
// Round-robin burst scheduler that serialises LANES-byte vector accesses from two
// requesters onto a single-port byte-wide data memory, packing and unpacking lane bytes.
module data_memory_scheduler #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      p0_valid,
    input  logic                      p0_we,
    input  logic [ADDR_W-1:0]         p0_addr,
    input  logic [LANES*DATA_W-1:0]   p0_wdata,
    output logic                      p0_ready,
    output logic                      p0_done,
    output logic [LANES*DATA_W-1:0]   p0_rdata,
    input  logic                      p1_valid,
    input  logic                      p1_we,
    input  logic [ADDR_W-1:0]         p1_addr,
    input  logic [LANES*DATA_W-1:0]   p1_wdata,
    output logic                      p1_ready,
    output logic                      p1_done,
    output logic [LANES*DATA_W-1:0]   p1_rdata,
    output logic [ADDR_W-1:0]         mem_address,
    output logic                      mem_wren,
    output logic [DATA_W-1:0]         mem_data,
    input  logic [DATA_W-1:0]         mem_q,
    output logic                      busy
);
    localparam int VEC_W  = LANES * DATA_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

    state_t              state, state_next;
    logic                rr_ptr, port_q, we_q;
    logic [ADDR_W-1:0]   base_q, last_addr, issue_addr;
    logic [VEC_W-1:0]    wdata_q, rbuf, rbuf_next;
    logic [LANE_W-1:0]   lane;
    logic [CNT_W-1:0]    drain_cnt;
    logic                grant, grant_port, last_capture;
    logic [RD_LAT-1:0]   pipe_vld;
    logic [LANE_W-1:0]   pipe_lane [RD_LAT];

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant      = 1'b0;
        grant_port = 1'b0;
        // Gating with rst_n keeps the ready strobes low while reset is held.
        if (state == IDLE && rst_n) begin
            if (p0_valid && p1_valid) begin
                grant      = 1'b1;
                grant_port = rr_ptr;
            end else if (p0_valid || p1_valid) begin
                grant      = 1'b1;
                grant_port = p1_valid;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = BURST;
            BURST:   if (lane == LAST_LANE) state_next = we_q ? DONE : DRAIN;
            DRAIN:   if (drain_cnt == LAST_CNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The oldest pipeline stage carries the lane whose read data is on mem_q this cycle.
    always_comb begin
        rbuf_next = rbuf;
        if (pipe_vld[RD_LAT-1])
            rbuf_next[pipe_lane[RD_LAT-1]*DATA_W +: DATA_W] = mem_q;
    end

    assign last_capture = (state == DRAIN) && (drain_cnt == LAST_CNT);
    assign issue_addr   = base_q + ADDR_W'(lane);
    assign mem_address  = (state == BURST) ? issue_addr : last_addr;
    assign mem_wren     = (state == BURST) && we_q;
    assign mem_data     = mem_wren ? wdata_q[lane*DATA_W +: DATA_W] : '0;
    assign busy         = (state != IDLE);
    assign p0_ready     = grant && !grant_port;
    assign p1_ready     = grant && grant_port;
    assign p0_done      = (state == DONE) && !port_q;
    assign p1_done      = (state == DONE) && port_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            base_q    <= '0;
            last_addr <= '0;
            wdata_q   <= '0;
            lane      <= '0;
            drain_cnt <= '0;
            rbuf      <= '0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            pipe_vld  <= '0;
            // NOTE: the lane pipeline is only RD_LAT entries deep, so resetting it costs little and keeps it X-free.
            for (int i = 0; i < RD_LAT; i++) pipe_lane[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state       <= state_next;
            rbuf        <= rbuf_next;
            pipe_vld[0] <= (state == BURST) && !we_q;
            pipe_lane[0] <= lane;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_lane[i] <= pipe_lane[i-1];
            end
            case (state)
                IDLE: if (grant) begin
                    port_q  <= grant_port;
                    we_q    <= grant_port ? p1_we    : p0_we;
                    base_q  <= grant_port ? p1_addr  : p0_addr;
                    wdata_q <= grant_port ? p1_wdata : p0_wdata;
                    lane    <= '0;
                end
                BURST: begin
                    last_addr <= issue_addr;
                    lane      <= lane + 1'b1;
                    drain_cnt <= '0;
                end
                DRAIN:   drain_cnt <= drain_cnt + 1'b1;
                DONE:    rr_ptr <= ~port_q;
                default: ;
            endcase
            if (last_capture) begin
                if (port_q) p1_rdata <= rbuf_next;
                else        p0_rdata <= rbuf_next;
            end
        end
    end
endmodule
